inst_fetch: RTL

- Upstream instruction-supply stage for the 8-bit processor.
- Accepts a program as a byte stream through a valid/ready loader and stores it in an internal register-file program memory.
- Once loaded, returns the registered instruction addressed by the processor's PC every cycle on INST.
- Detects a HALT opcode and freezes the instruction stream to NOP.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/prog_mem.sv | 35 +++
 rtl/inst_fetch.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and
// default geometry/opcode values used by inst_fetch and prog_mem.
package fetch_pkg;

    localparam int          DEPTH_DEF   = 32;
    localparam int          ADDR_W_DEF  = 5;
    localparam logic [7:0]  HALT_OP_DEF = 8'hFF;
    localparam logic [7:0]  NOP_OP_DEF  = 8'h00;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program memory: DEPTH x 8 register file, one write port and one
// combinational read port. Every word resets to NOP_OP so unloaded
// locations fetch as no-ops.
module prog_mem
    import fetch_pkg::*;
#(
    parameter int         DEPTH  = DEPTH_DEF,
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter logic [7:0] NOP_OP = NOP_OP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    // Storage array: cleared to NOP on reset, written one byte per transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_OP;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: loads a program byte stream into prog_mem, then
// serves the word addressed by PC each cycle until a HALT opcode is fetched.
// Optional loader checksum on ld_sum is enabled by defining
// INST_FETCH_CHECKSUM_EN; otherwise ld_sum is tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | accepting loader bytes into memory, INST held at NOP
// RUN   | INST <= mem[PC] every cycle, out-of-range PC flags range_err
// HALT  | HALT opcode was fetched; INST frozen at NOP until reload
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int         DEPTH   = DEPTH_DEF,
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter logic [7:0] HALT_OP = HALT_OP_DEF,
    parameter logic [7:0] NOP_OP  = NOP_OP_DEF
) (
    input  logic       clk,
    input  logic       CLB,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    input  logic       reload,
    input  logic [7:0] PC,
    output logic [7:0] INST,
    output logic       inst_valid,
    output logic       halted,
    output logic       range_err,
    output logic [7:0] ld_sum
);

    // Range check uses the full 8-bit PC, so compare at 9 bits to allow DEPTH=256.
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    fetch_state_t      state;
    logic [ADDR_W-1:0] wptr;
    logic [7:0]        rdata;
    logic              xfer;
    logic              wptr_last;
    logic              pc_in_range;

    assign ld_ready    = (state == ST_LOAD);
    assign xfer        = ld_ready && ld_valid;
    assign wptr_last   = (wptr == ADDR_W'(DEPTH - 1));
    assign pc_in_range = ({1'b0, PC} < DEPTH_W);

    prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .NOP_OP (NOP_OP)
    ) u_prog_mem (
        .clk   (clk),
        .rst_n (CLB),
        .we    (xfer),
        .waddr (wptr),
        .wdata (ld_data),
        .raddr (PC[ADDR_W-1:0]),
        .rdata (rdata)
    );

    // Sequencer, write pointer and registered fetch outputs.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state      <= ST_LOAD;
            wptr       <= '0;
            INST       <= NOP_OP;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    INST       <= NOP_OP;
                    inst_valid <= 1'b0;
                    if (xfer) begin
                        // Pointer stops at the last word; a full memory ends the load.
                        if (!wptr_last) begin
                            wptr <= wptr + ADDR_W'(1);
                        end
                        if (ld_last || wptr_last) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        state      <= ST_LOAD;
                        wptr       <= '0;
                        INST       <= NOP_OP;
                        inst_valid <= 1'b0;
                        halted     <= 1'b0;
                        range_err  <= 1'b0;
                    end else if (inst_valid && (INST == HALT_OP)) begin
                        state      <= ST_HALT;
                        INST       <= NOP_OP;
                        inst_valid <= 1'b0;
                        halted     <= 1'b1;
                    end else begin
                        inst_valid <= 1'b1;
                        if (pc_in_range) begin
                            INST <= rdata;
                        end else begin
                            INST      <= NOP_OP;
                            range_err <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    INST       <= NOP_OP;
                    inst_valid <= 1'b0;
                    if (reload) begin
                        state     <= ST_LOAD;
                        wptr      <= '0;
                        halted    <= 1'b0;
                        range_err <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_LOAD;
                    wptr       <= '0;
                    INST       <= NOP_OP;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef INST_FETCH_CHECKSUM_EN
    // Modulo-256 sum of accepted loader bytes; restarts when a reload enters LOAD.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            ld_sum <= 8'h00;
        end else if (reload && (state != ST_LOAD)) begin
            ld_sum <= 8'h00;
        end else if (xfer) begin
            ld_sum <= ld_sum + ld_data;
        end
    end
`else
    assign ld_sum = 8'h00;
`endif

endmodule
